// File: rtl/sha2_msg_sched.sv
// SHA-2 message-schedule engine: loads a 16-word block, then streams W[0..ROUNDS-1]
// over a valid/ready port. WORD_W=32 selects SHA-256, WORD_W=64 selects SHA-512.
module sha2_msg_sched #(
  parameter  int WORD_W = 32,
  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64,
  localparam int T_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              m_valid_i,
  input  logic [WORD_W-1:0] m_i,
  output logic              m_ready_o,
  output logic              wt_valid_o,
  input  logic              wt_ready_i,
  output logic [WORD_W-1:0] wt_o,
  output logic [T_W-1:0]    t_o,
  output logic              last_o,
  output logic              busy_o
);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_msg_sched: WORD_W must be 32 or 64");
    end
  endgenerate

  localparam int S0_A = (WORD_W == 64) ? 1  : 7;
  localparam int S0_B = (WORD_W == 64) ? 8  : 18;
  localparam int S0_C = (WORD_W == 64) ? 7  : 3;
  localparam int S1_A = (WORD_W == 64) ? 19 : 17;
  localparam int S1_B = (WORD_W == 64) ? 61 : 19;
  localparam int S1_C = (WORD_W == 64) ? 6  : 10;
  localparam logic [T_W-1:0] T_LAST = T_W'(ROUNDS - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [4:0]        lc_q;
  logic [T_W-1:0]    t_q;
  logic [WORD_W-1:0] r_q [16];
  logic              m_ready_q;
  logic              wt_valid_q;
  logic [WORD_W-1:0] w_new_d;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
  endfunction

  // Next schedule word from the sliding window: r[0]=W[t], r[1]=W[t+1], r[9]=W[t+9], r[14]=W[t+14].
  always_comb begin
    w_new_d = r_q[0] + sig0(r_q[1]) + r_q[9] + sig1(r_q[14]);
  end

  // Control FSM with registered handshake outputs; flush outranks both handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      lc_q       <= 5'd0;
      t_q        <= '0;
      m_ready_q  <= 1'b0;
      wt_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
    end else if (flush_i) begin
      state_q    <= ST_LOAD;
      lc_q       <= 5'd0;
      t_q        <= '0;
      m_ready_q  <= 1'b1;
      wt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          m_ready_q  <= 1'b1;
          wt_valid_q <= 1'b0;
          if (m_valid_i && m_ready_q) begin
            for (int i = 0; i < 15; i++) r_q[i] <= r_q[i+1];
            r_q[15] <= m_i;
            if (lc_q == 5'd15) begin
              lc_q       <= 5'd0;
              t_q        <= '0;
              state_q    <= ST_RUN;
              m_ready_q  <= 1'b0;
              wt_valid_q <= 1'b1;
            end else begin
              lc_q <= lc_q + 5'd1;
            end
          end
        end
        ST_RUN: begin
          if (wt_ready_i) begin
            for (int i = 0; i < 15; i++) r_q[i] <= r_q[i+1];
            r_q[15] <= w_new_d;
            if (t_q == T_LAST) begin
              t_q        <= '0;
              state_q    <= ST_LOAD;
              m_ready_q  <= 1'b1;
              wt_valid_q <= 1'b0;
            end else begin
              t_q <= t_q + T_W'(1);
            end
          end
        end
        default: begin
          state_q    <= ST_LOAD;
          lc_q       <= 5'd0;
          t_q        <= '0;
          m_ready_q  <= 1'b0;
          wt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_ready_o  = m_ready_q;
  assign wt_valid_o = wt_valid_q;
  assign wt_o       = r_q[0];
  assign t_o        = t_q;
  assign last_o     = wt_valid_q && (t_q == T_LAST);
  assign busy_o     = (state_q != ST_LOAD) || (lc_q != 5'd0);

endmodule
